// File: rtl/pc_fetch.sv
// Program-counter fetch unit: sequences instruction addresses, resolves absolute or
// PC-relative branches through an external target table, and counts taken branches.
module pc_fetch #(
  parameter int D  = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          rel,
  input  logic [3:0]    br_idx,
  output logic [3:0]    lut_addr,
  input  logic [D-1:0]  lut_target,
  input  logic          halt_req,
  output logic [D-1:0]  prog_addr,
  output logic          fetch_valid,
  output logic          done,
  output logic [CW-1:0] branch_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

  state_t              state, state_nxt;
  logic [D-1:0]        addr_nxt;
  logic [CW-1:0]       count_nxt;
  logic signed [D-1:0] offset;
  logic signed [D-1:0] rel_sum;
  logic [D-1:0]        br_target;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign lut_addr = br_idx;

  // Relative targets treat the table entry as a signed offset; the sum wraps at 2^D.
  assign offset    = signed'(lut_target);
  assign rel_sum   = signed'(prog_addr) + offset;
  assign br_target = rel ? $unsigned(rel_sum) : lut_target;

  always_comb begin
    state_nxt = state;
    addr_nxt  = prog_addr;
    count_nxt = branch_count;
    case (state)
      IDLE: begin
        addr_nxt = '0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_nxt = HALT;
        end else if (stall) begin
          state_nxt = RUN;
        end else if (branch_en) begin
          state_nxt = FLUSH;
          addr_nxt  = br_target;
          count_nxt = sat_inc(branch_count);
        end else begin
          addr_nxt = prog_addr + 1'b1;
        end
      end
      FLUSH:   state_nxt = RUN;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prog_addr    <= '0;
      branch_count <= '0;
    end else begin
      state        <= state_nxt;
      prog_addr    <= addr_nxt;
      branch_count <= count_nxt;
    end
  end

  assign fetch_valid = (state == RUN);
  assign done        = (state == HALT);

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios, a cycle-level reference model, and
// literal checkpoints; a second instance with CW=2 exercises counter saturation.
module tb_pc_fetch;

  localparam int D = 10;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch_en, rel, halt_req;
  logic [3:0] br_idx;
  logic [D-1:0] lut_target;

  logic [3:0]   lut_addr, lut_addr2;
  logic [D-1:0] prog_addr, prog_addr2;
  logic         fetch_valid, fetch_valid2, done, done2;
  logic [7:0]   branch_count;
  logic [1:0]   branch_count2;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch #(.D(D), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch_en(branch_en),
    .rel(rel), .br_idx(br_idx), .lut_addr(lut_addr), .lut_target(lut_target),
    .halt_req(halt_req), .prog_addr(prog_addr), .fetch_valid(fetch_valid),
    .done(done), .branch_count(branch_count)
  );

  pc_fetch #(.D(D), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch_en(branch_en),
    .rel(rel), .br_idx(br_idx), .lut_addr(lut_addr2), .lut_target(lut_target),
    .halt_req(halt_req), .prog_addr(prog_addr2), .fetch_valid(fetch_valid2),
    .done(done2), .branch_count(branch_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle,1=running,2=flushing,3=halted; address kept as an integer.
  int  m_mode = 0;
  int  m_addr = 0;
  int  m_cnt  = 0;
  int  m_cnt2 = 0;
  bit  armed  = 0;

  always @(posedge clk) begin
    int off;
    if (reset) begin
      m_mode = 0; m_addr = 0; m_cnt = 0; m_cnt2 = 0; armed = 1;
    end else if (m_mode == 0) begin
      m_addr = 0;
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt_req) m_mode = 3;
      else if (stall) m_mode = 1;
      else if (branch_en) begin
        off = (int'(lut_target) >= 512) ? int'(lut_target) - 1024 : int'(lut_target);
        m_addr = rel ? (m_addr + off + 1024) % 1024 : int'(lut_target);
        m_mode = 2;
        m_cnt  = (m_cnt  == 255) ? 255 : m_cnt + 1;
        m_cnt2 = (m_cnt2 == 3)   ? 3   : m_cnt2 + 1;
      end else m_addr = (m_addr + 1) % 1024;
    end else if (m_mode == 2) begin
      m_mode = 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("prog_addr",     int'(prog_addr),     m_addr);
      chk("fetch_valid",   int'(fetch_valid),   int'(m_mode == 1));
      chk("done",          int'(done),          int'(m_mode == 3));
      chk("branch_count",  int'(branch_count),  m_cnt);
      chk("lut_addr",      int'(lut_addr),      int'(br_idx));
      chk("prog_addr2",    int'(prog_addr2),    m_addr);
      chk("branch_count2", int'(branch_count2), m_cnt2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; stall = 0; branch_en = 0; rel = 0; halt_req = 0; br_idx = 0; lut_target = 0;
  endtask

  task automatic take_branch(input logic r, input logic [3:0] idx, input logic [D-1:0] tgt);
    branch_en = 1; rel = r; br_idx = idx; lut_target = tgt;
    tick();
    idle_in();
  endtask

  initial begin
    idle_in();
    reset = 1;
    tick(); tick();
    chk("rst_addr", int'(prog_addr), 0);
    chk("rst_valid", int'(fetch_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(branch_count), 0);
    reset = 0;

    // Start, then five sequential fetches 0..4.
    start = 1; tick(); start = 0;
    chk("seq_addr0", int'(prog_addr), 0);
    chk("seq_valid0", int'(fetch_valid), 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_addr", int'(prog_addr), i);
    end

    // Halt; absorbing while other inputs wiggle.
    halt_req = 1; tick(); halt_req = 0;
    chk("halt_done", int'(done), 1);
    for (int i = 0; i < 10; i++) begin
      branch_en = 1; stall = i[0]; start = i[1]; lut_target = 10'd300;
      tick();
    end
    idle_in();
    start = 1; tick(); start = 0;
    chk("halt_addr", int'(prog_addr), 4);
    chk("halt_done2", int'(done), 1);
    chk("halt_valid", int'(fetch_valid), 0);

    // Reset from HALT, restart, walk to address 4.
    reset = 1; tick(); reset = 0;
    chk("rst_halt_done", int'(done), 0);
    chk("rst_halt_addr", int'(prog_addr), 0);
    start = 1; tick(); start = 0;
    chk("restart_addr", int'(prog_addr), 0);
    repeat (4) tick();
    chk("at4", int'(prog_addr), 4);

    // Absolute branch to 110.
    branch_en = 1; rel = 0; br_idx = 4'd3; lut_target = 10'd110;
    #1 chk("lut_addr_lit", int'(lut_addr), 3);
    tick(); idle_in();
    chk("br_addr", int'(prog_addr), 110);
    chk("br_flush_valid", int'(fetch_valid), 0);
    chk("br_count", int'(branch_count), 1);
    tick();
    chk("br_valid", int'(fetch_valid), 1);
    chk("br_addr_run", int'(prog_addr), 110);
    tick();
    chk("br_next", int'(prog_addr), 111);

    // Back to 4, with inputs asserted during FLUSH that must be ignored.
    branch_en = 1; lut_target = 10'd4; tick();
    branch_en = 1; start = 1; stall = 1; lut_target = 10'd77; tick(); idle_in();
    chk("flush_ignore", int'(prog_addr), 4);
    chk("cnt2_at2", int'(branch_count2), 2);

    // Relative -5 from 4 wraps to 1023, then increments to 0.
    take_branch(1'b1, 4'd5, 10'h3FB);
    chk("rel_wrap", int'(prog_addr), 1023);
    tick();
    tick();
    chk("inc_wrap", int'(prog_addr), 0);
    chk("cnt2_at3", int'(branch_count2), 3);

    // Stall beats a concurrent branch.
    take_branch(1'b0, 4'd1, 10'd20);
    tick();
    chk("at20", int'(prog_addr), 20);
    chk("cnt2_sat4", int'(branch_count2), 3);
    stall = 1; branch_en = 1; lut_target = 10'd500;
    repeat (3) tick();
    idle_in();
    chk("stall_addr", int'(prog_addr), 20);
    chk("stall_count", int'(branch_count), 4);
    tick();
    chk("unstall", int'(prog_addr), 21);

    take_branch(1'b0, 4'd2, 10'd100);
    chk("cnt_5", int'(branch_count), 5);
    chk("cnt2_sat5", int'(branch_count2), 3);
    tick();

    // Reset during FLUSH; reset beats a same-cycle start.
    take_branch(1'b0, 4'd7, 10'd200);
    reset = 1; tick();
    chk("rst_flush_addr", int'(prog_addr), 0);
    chk("rst_flush_count", int'(branch_count), 0);
    start = 1; tick(); reset = 0; start = 0;
    tick();
    chk("start_lost", int'(fetch_valid), 0);
    start = 1; tick(); start = 0;
    chk("resume_valid", int'(fetch_valid), 1);
    tick();
    chk("resume_addr", int'(prog_addr), 1);

    // Halt outranks stall and branch.
    halt_req = 1; stall = 1; branch_en = 1; lut_target = 10'd9; tick(); idle_in();
    chk("halt_prio_done", int'(done), 1);
    chk("halt_prio_cnt", int'(branch_count), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter D, default 10, program-address width in bits.
REQ-002 Parameter CW, default 8, branch-counter width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 start  input  1  one-cycle pulse; begin fetching from address 0.
REQ-006 stall  input  1  hold current fetch address.
REQ-007 branch_en  input  1  current instruction is a taken branch.
REQ-008 rel  input  1  1 = target is a signed offset from prog_addr; 0 = target is an absolute address.
REQ-009 br_idx  input  4  branch-table index from the instruction.
REQ-010 lut_addr  output  4  index driven to the branch-target table; combinationally equal to br_idx.
REQ-011 lut_target  input  D  table entry for lut_addr, valid in the same cycle (combinational table).
REQ-012 halt_req  input  1  current instruction is a halt.
REQ-013 prog_addr  output  D  registered fetch address.
REQ-014 fetch_valid  output  1  prog_addr is a live fetch this cycle.
REQ-015 done  output  1  program halted; sticky.
REQ-016 branch_count  output  CW  count of taken branches, saturating.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, FLUSH and HALT; fetch_valid SHALL be 1 only in RUN; done SHALL be 1 only in HALT.
REQ-018 In IDLE: on start=1, go to RUN with prog_addr=0; otherwise hold prog_addr=0; all other inputs are ignored.
REQ-019 In RUN, input priority SHALL be halt_req > stall > branch_en > increment.
REQ-020 RUN with halt_req=1: go to HALT; prog_addr holds.
REQ-021 RUN with stall=1 and halt_req=0: prog_addr holds, state stays RUN; a concurrent branch_en is dropped and is not counted.
REQ-022 RUN with branch_en=1, rel=0: next prog_addr = lut_target.
REQ-023 RUN with branch_en=1, rel=1: next prog_addr = (prog_addr + lut_target) mod 2^D, lut_target read as two's complement (e.g. all-ones = -1).
REQ-024 Each taken branch (REQ-022/023) SHALL move the FSM to FLUSH and increment branch_count; branch_count saturates at 2^CW-1.
REQ-025 RUN otherwise: prog_addr <= (prog_addr + 1) mod 2^D; 2^D-1 wraps to 0.
REQ-026 FLUSH SHALL last exactly one cycle: prog_addr holds the branch target, fetch_valid=0, all inputs are ignored, then go to RUN with prog_addr unchanged.
REQ-027 HALT SHALL be absorbing until reset; start and all other inputs are ignored; prog_addr holds.
REQ-028 Start in RUN or FLUSH SHALL be ignored.
REQ-029 Branch latency: the target appears on prog_addr on the first clock edge after the branch cycle; the first valid fetch of the target is one cycle later.

Reset
REQ-030 With reset=1 at a rising edge, state SHALL become IDLE, prog_addr=0, fetch_valid=0, done=0, branch_count=0, overriding every other input, from any state including FLUSH and HALT.
REQ-031 reset SHALL take priority over a start asserted in the same cycle; that start is lost.

Verification
REQ-032 Reset, start pulse, 5 idle-input cycles -> prog_addr 0,1,2,3,4 with fetch_valid=1; then halt_req -> done=1, prog_addr=4 held for 10 cycles; then start -> no change.
REQ-033 At prog_addr=4: br_idx=3, lut_target=110, rel=0, branch_en -> lut_addr=3; next cycle prog_addr=110 with fetch_valid=0; then fetch_valid=1 at 110, then 111; branch_count=1.
REQ-034 At prog_addr=4: lut_target=10'h3FB (-5), rel=1 -> target 1023 (wrap); following increment -> 0.
REQ-035 At prog_addr=20: stall=1 and branch_en=1 together for 3 cycles -> prog_addr=20 held, branch_count unchanged; stall=0 -> 21.
REQ-036 CW=2: 5 taken branches -> branch_count 1,2,3,3,3.
REQ-037 reset asserted during FLUSH and during HALT -> next cycle IDLE, all outputs 0; a subsequent start resumes at address 0.
